// File: rtl/wide_add_seq.sv
// Wide add/subtract sequencer: feeds one byte slice per cycle to an external
// 8-bit adder and assembles an NBYTES-wide result with carry-out and signed
// overflow, using valid/ready handshakes on both the operand and result sides.
module wide_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [8:0]            add_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_res;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_ovf;
  logic              w_accept;
  logic              w_lastSlice;
  logic [W-1:0]      w_shA;
  logic [W-1:0]      w_shB;

  // Shift the current byte slice down to bit 0 so it can be picked off directly.
  assign w_shA = r_a >> {r_idx, 3'b000};
  assign w_shB = r_b >> {r_idx, 3'b000};

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs; DONE can accept a new op in the same
  // cycle its result is taken, which keeps back-to-back ops bubble-free.
  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_lastSlice = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_lastSlice = 1'b1;
          w_next      = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_next   = RUN;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Drive the external adder only while slicing; it sees zeros otherwise.
  always_comb begin
    add_a   = 8'd0;
    add_b   = 8'd0;
    add_cin = 1'b0;
    if (r_state == RUN) begin
      add_a   = w_shA[7:0];
      add_b   = w_shB[7:0];
      add_cin = r_carry;
    end
  end

  // Operand latch, per-slice accumulation, and the result registers that are
  // loaded only on the final slice so they hold until the next op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_sub ? ~in_b : in_b;
        r_carry <= in_sub ? 1'b1 : in_cin;
        r_idx   <= '0;
      end else if (r_state == RUN) begin
        r_res[{r_idx, 3'b000} +: 8] <= add_sum[7:0];
        r_carry                     <= add_sum[8];
        if (!w_lastSlice) r_idx <= r_idx + 1'b1;
      end
      if (w_lastSlice) begin
        r_sum  <= {add_sum[7:0], r_res[W-9:0]};
        r_cout <= add_sum[8];
        r_ovf  <= (r_a[W-1] == r_b[W-1]) & (add_sum[7] != r_a[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with NBYTES=4; the external 8-bit adder is
// modelled as a plain combinational 9-bit add.
module tb_wide_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_cin;
  logic [8:0]    add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          busy;

  int nCompared   = 0;
  int nMismatched = 0;

  wide_add_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  // Behavioural stand-in for the 8-bit adder stage.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one op: handshake in, track latency and per-slice add_cin, scramble
  // the operand inputs after acceptance, then take the result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin,
                       output logic [W-1:0] sum, output logic cout,
                       output logic ovf, output int lat, output logic [7:0] cinTrace);
    int guard;
    cinTrace = 8'd0;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    nCompared++;
    if (!in_ready) begin
      nMismatched++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 32'hDEADBEEF; in_b = 32'hA5A5A5A5; in_cin = ~cin; in_sub = 1'b0;
    cinTrace[0] = add_cin;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
      cinTrace[lat[2:0]] = add_cin;
    end
    nCompared++;
    if (!out_valid) begin
      nMismatched++;
      $display("[TB] FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
    sum = out_sum; cout = out_cout; ovf = out_ovf;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // Reset state while rst_n is held low.
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(negedge clk);
    nCompared++;
    if ({in_ready, out_valid, busy, out_cout, out_ovf} !== 5'b10000 || out_sum !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: rdy/vld/busy/cout/ovf=%b sum=%h required 10000 sum=0",
               {in_ready, out_valid, busy, out_cout, out_ovf}, out_sum);
    end
    nCompared++;
    if ({add_a, add_b, add_cin} !== 17'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_adder: a=%h b=%h cin=%b required 0", add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // 0xFF + 1: carry into byte 1, exact 4-clock latency.
  task automatic test_add();
    logic [W-1:0] s; logic c, v; int lat; logic [7:0] tr;
    do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, s, c, v, lat, tr);
    nCompared++;
    if (s !== 32'h00000100 || c !== 1'b0 || v !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL add_result: sum=%h cout=%b ovf=%b required 00000100 0 0", s, c, v);
    end
    nCompared++;
    if (lat != 4) begin
      nMismatched++;
      $display("[TB] FAIL add_latency: %0d clocks required 4", lat);
    end
    nCompared++;
    if (tr[1:0] !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL add_cin_trace: byte1/byte0=%b required 10", tr[1:0]);
    end
  endtask

  // Full-width wrap with explicit operand and with carry-in.
  task automatic test_wrap();
    logic [W-1:0] s; logic c, v; int lat; logic [7:0] tr;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, s, c, v, lat, tr);
    nCompared++;
    if (s !== 32'h0 || c !== 1'b1 || v !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL wrap_b1: sum=%h cout=%b ovf=%b required 00000000 1 0", s, c, v);
    end
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, s, c, v, lat, tr);
    nCompared++;
    if (s !== 32'h0 || c !== 1'b1 || v !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL wrap_cin: sum=%h cout=%b ovf=%b required 00000000 1 0", s, c, v);
    end
  endtask

  // Positive + positive going negative.
  task automatic test_ovf();
    logic [W-1:0] s; logic c, v; int lat; logic [7:0] tr;
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, s, c, v, lat, tr);
    nCompared++;
    if (s !== 32'h80000000 || c !== 1'b0 || v !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ovf_result: sum=%h cout=%b ovf=%b required 80000000 0 1", s, c, v);
    end
  endtask

  // Subtract with and without borrow; in_cin must be ignored.
  task automatic test_sub();
    logic [W-1:0] s; logic c, v; int lat; logic [7:0] tr;
    do_op(32'd5, 32'd7, 1'b1, 1'b1, s, c, v, lat, tr);
    nCompared++;
    if (s !== 32'hFFFFFFFE || c !== 1'b0 || v !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL sub_borrow: sum=%h cout=%b ovf=%b required FFFFFFFE 0 0", s, c, v);
    end
    do_op(32'd7, 32'd5, 1'b1, 1'b0, s, c, v, lat, tr);
    nCompared++;
    if (s !== 32'd2 || c !== 1'b1 || v !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL sub_noborrow: sum=%h cout=%b ovf=%b required 00000002 1 0", s, c, v);
    end
  endtask

  // Hold the result under backpressure, then release with a new op queued.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd4; in_sub = 1'b0; in_cin = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nCompared++;
      if (out_valid !== 1'b1 || out_sum !== 32'd7 || in_ready !== 1'b0 || out_cout !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL hold_%0d: vld=%b sum=%h rdy=%b required 1 00000007 0",
                 i, out_valid, out_sum, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'h10; in_b = 32'h20;
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    nCompared++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || out_sum !== 32'd7) begin
      nMismatched++;
      $display("[TB] FAIL b2b_accept: vld=%b busy=%b sum=%h required 0 1 00000007",
               out_valid, busy, out_sum);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    nCompared++;
    if (lat != 4 || out_sum !== 32'h30) begin
      nMismatched++;
      $display("[TB] FAIL b2b_result: lat=%0d sum=%h required 4 00000030", lat, out_sum);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // Abort an op at slice 2 and confirm a clean restart.
  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic c, v; int lat; logic [7:0] tr;
    logic sawValid;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'h1; in_sub = 1'b0; in_cin = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if ({out_valid, busy, out_cout, out_ovf, add_cin} !== 5'd0 || out_sum !== '0 ||
        add_a !== 8'd0 || add_b !== 8'd0 || in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midrun_reset: vld=%b busy=%b sum=%h add_a=%h rdy=%b required 0 0 0 0 1",
               out_valid, busy, out_sum, add_a, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) sawValid = 1'b1; end
    nCompared++;
    if (sawValid !== 1'b0 || in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midrun_noresult: out_valid seen=%b rdy=%b required 0 1", sawValid, in_ready);
    end
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, s, c, v, lat, tr);
    nCompared++;
    if (s !== 32'h23456789 || c !== 1'b0 || v !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midrun_restart: sum=%h cout=%b ovf=%b required 23456789 0 0", s, c, v);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_ovf();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that builds an NBYTES-wide add/subtract from the team's 8-bit carry-increment adder stage.
- Upstream: latches wide operands through a valid/ready handshake.
- Toward the adder: drives one byte slice plus carry-in per cycle, and registers the returned 9-bit sum.
- Downstream: presents the assembled wide result with carry-out and signed overflow through a second valid/ready handshake.

Parameters:
NBYTES, 4, number of 8-bit slices; result width is 8*NBYTES; legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
in_a  input  8*NBYTES  operand A
in_b  input  8*NBYTES  operand B
in_cin  input  1  carry-in for add mode
in_sub  input  1  1 = A-B, 0 = A+B+cin
add_a  output  8  byte slice of A to the 8-bit adder
add_b  output  8  byte slice of B (post-inversion) to the 8-bit adder
add_cin  output  1  carry to the 8-bit adder
add_sum  input  9  adder result; bit 8 is the slice carry-out; combinational same-cycle return
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  8*NBYTES  wide result
out_cout  output  1  final carry-out; in sub mode 1 = no borrow
out_ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN

Behaviour:
- Reset state (async, while rst_n=0): state IDLE, all registers 0.
  - in_ready=1 after reset.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0.
  - add_a=0, add_b=0, add_cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a_reg=in_a, b_reg = in_sub ? ~in_b : in_b.
  - carry_reg = in_sub ? 1 : in_cin (in_cin ignored in sub mode).
  - idx=0; go to RUN.
- RUN:
  - add_a = a_reg[8*idx+7:8*idx], add_b = b_reg byte idx, add_cin = carry_reg.
  - At each edge: res[byte idx] <= add_sum[7:0], carry_reg <= add_sum[8], idx <= idx+1.
  - When idx==NBYTES-1: go to DONE instead of incrementing.
  - Outside RUN, add_a/add_b/add_cin are driven 0.
  - in_ready=0; in_valid is ignored.
- Latency: with accept edge E0, out_valid rises after edge E{NBYTES}, i.e. 4 clocks for the default.
- DONE:
  - out_valid=1; out_sum=res; out_cout=carry_reg.
  - out_ovf = (a_reg msb == b_reg msb) & (res msb != a_reg msb), with b_reg already inverted in sub mode.
  - All outputs are held stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE.
  - in_ready = out_ready in DONE. If in_valid is also high, the new operands are latched in the same cycle and the FSM goes directly to RUN (back-to-back, no bubble).
- out_sum/out_cout/out_ovf:
  - Registered; they retain their last value after the handshake until the next DONE.
  - Only out_valid qualifies them.
- idx counter width: clog2(NBYTES); never exceeds NBYTES-1.
- Reset mid-operation: asserting rst_n low in any state forces reset values immediately. The partial result is discarded, and no out_valid is issued for the aborted op.
- An X or change on in_a/in_b after acceptance has no effect (operands are latched).

Test Plan:
- Pure add, NBYTES=4: in_a=0x000000FF, in_b=0x00000001, in_sub=0, in_cin=0 -> out_sum=0x00000100, out_cout=0, out_ovf=0. out_valid rises exactly 4 clocks after the accept edge; add_cin=1 during byte 1.
- Full wrap: in_a=0xFFFFFFFF, in_b=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_ovf=0. Also in_a=0xFFFFFFFF, in_b=0, cin=1 -> same result.
- Signed overflow: in_a=0x7FFFFFFF, in_b=0x00000001 -> out_sum=0x80000000, out_cout=0, out_ovf=1.
- Subtract with borrow: in_a=5, in_b=7, in_sub=1, in_cin=1 (must be ignored) -> out_sum=0xFFFFFFFE, out_cout=0, out_ovf=0. In the same run, 7-5 -> out_sum=2, out_cout=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0.
  - Raise out_ready with in_valid=1 (0x10+0x20) -> handshake completes and the new op is accepted the same cycle.
  - The new op's result 0x00000030 appears 4 clocks later.
- Reset mid-RUN: pull rst_n low at idx=2 -> all outputs 0 immediately, no out_valid. After release: in_ready=1, and a following 0x12345678+0x11111111 gives out_sum=0x23456789.
